// File: rtl/child_rr_scheduler_if.sv
// child_rr_scheduler_if: request/grant bundle between one hierarchy level's children and its round-robin scheduler.
//   req, last, res_ready : child/resource side -> scheduler
//   gnt, gnt_valid, gnt_idx, beat_cnt, grant_cnt, abort_pulse : scheduler -> children/status
//   modport master : the children/resource side that drives requests
//   modport slave  : the scheduler that answers with grants
interface child_rr_scheduler_if #(
   parameter int NUM_REQ = 5,
   parameter int IDX_W   = 3,
   parameter int CNT_W   = 16
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] last;
   logic               res_ready;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic [7:0]         beat_cnt;
   logic [CNT_W-1:0]   grant_cnt;
   logic               abort_pulse;
   modport master (
      output req, last, res_ready,
      input  gnt, gnt_valid, gnt_idx, beat_cnt, grant_cnt, abort_pulse
   );
   modport slave (
      input  req, last, res_ready,
      output gnt, gnt_valid, gnt_idx, beat_cnt, grant_cnt, abort_pulse
   );
endinterface

// File: rtl/child_rr_scheduler.sv
// child_rr_scheduler: round-robin grant of one shared resource slot among NUM_REQ children, metering bursts.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : child_rr_scheduler_if.slave
//         in  req/last (per child), res_ready
//         out gnt (one-hot), gnt_valid, gnt_idx, beat_cnt, grant_cnt (saturating), abort_pulse
module child_rr_scheduler #(
   parameter int NUM_REQ   = 5,
   parameter int MAX_BURST = 4,
   parameter int IDX_W     = 3,
   parameter int CNT_W     = 16
) (
   input logic                 clk,
   input logic                 rst,
   child_rr_scheduler_if.slave bus
);
   typedef enum logic {ARB, GRANT} state_t;
   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] lo_idx, hi_idx, winner;
   logic             any_req, hi_found;
   logic             req_g, last_g, beat, abort, done;
   // Rotating priority without modulo: the lowest requester at or above ptr wins,
   // otherwise the search has wrapped and the lowest requester overall wins.
   always_comb begin
      lo_idx   = '0;
      hi_idx   = '0;
      any_req  = 1'b0;
      hi_found = 1'b0;
      for (int j = NUM_REQ-1; j >= 0; j--) begin
         if (bus.req[j]) begin
            lo_idx  = IDX_W'(j);
            any_req = 1'b1;
            if (j >= int'(ptr)) begin
               hi_idx   = IDX_W'(j);
               hi_found = 1'b1;
            end
         end
      end
      winner = hi_found ? hi_idx : lo_idx;
   end
   // Masking with the one-hot grant ignores last/req of non-granted children.
   assign req_g  = |(bus.req & bus.gnt);
   assign last_g = |(bus.last & bus.gnt);
   assign abort  = (state == GRANT) && !req_g;
   assign beat   = bus.gnt_valid && bus.res_ready && req_g;
   assign done   = (state == GRANT) && (abort || (beat && (last_g || bus.beat_cnt == 8'(MAX_BURST-1))));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ARB;
         ptr             <= '0;
         bus.gnt         <= '0;
         bus.gnt_valid   <= 1'b0;
         bus.gnt_idx     <= '0;
         bus.beat_cnt    <= '0;
         bus.grant_cnt   <= '0;
         bus.abort_pulse <= 1'b0;
      end else begin
         bus.abort_pulse <= abort;
         if (state == ARB) begin
            if (any_req) begin
               state         <= GRANT;
               bus.gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
               bus.gnt_valid <= 1'b1;
               bus.gnt_idx   <= winner;
               bus.beat_cnt  <= '0;
            end
         end else begin
            // Abort wins over a simultaneous beat, so the beat is not counted.
            if (beat && !abort)
               bus.beat_cnt <= bus.beat_cnt + 8'd1;
            if (done) begin
               state         <= ARB;
               bus.gnt       <= '0;
               bus.gnt_valid <= 1'b0;
               bus.gnt_idx   <= '0;
               ptr           <= (bus.gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : bus.gnt_idx + 1'b1;
               if (!abort && !(&bus.grant_cnt))
                  bus.grant_cnt <= bus.grant_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_child_rr_scheduler.sv
// tb_child_rr_scheduler: directed self-checking bench for child_rr_scheduler (NUM_REQ=5, MAX_BURST=4).
module tb_child_rr_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   child_rr_scheduler_if #(.NUM_REQ(5), .IDX_W(3), .CNT_W(16)) bus ();
   child_rr_scheduler #(.NUM_REQ(5), .MAX_BURST(4), .IDX_W(3), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic one(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
      end
   endtask
   task automatic chk(input string tag, input logic [4:0] g, input logic [2:0] i, input logic [7:0] b,
                      input logic [15:0] c, input logic a);
      one(tag, "gnt", 32'(bus.gnt), 32'(g));
      one(tag, "gnt_valid", 32'(bus.gnt_valid), 32'(|g));
      one(tag, "gnt_idx", 32'(bus.gnt_idx), 32'(i));
      one(tag, "beat_cnt", 32'(bus.beat_cnt), 32'(b));
      one(tag, "grant_cnt", 32'(bus.grant_cnt), 32'(c));
      one(tag, "abort_pulse", 32'(bus.abort_pulse), 32'(a));
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.req = '0;
      bus.last = '0;
      bus.res_ready = 1'b0;
      #1;
      chk(tag, 5'b0, 3'd0, 8'd0, 16'd0, 1'b0);
      tick();
      rst = 1'b0;
   endtask
   initial begin
      bus.req = '0;
      bus.last = '0;
      bus.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 5'b0, 3'd0, 8'd0, 16'd0, 1'b0);
      rst = 1'b0;
      // single requester, burst limited by MAX_BURST
      bus.req = 5'b00001;
      bus.res_ready = 1'b1;
      tick(); chk("t1_grant", 5'b00001, 3'd0, 8'd0, 16'd0, 1'b0);
      tick(); chk("t1_beat1", 5'b00001, 3'd0, 8'd1, 16'd0, 1'b0);
      tick(); chk("t1_beat2", 5'b00001, 3'd0, 8'd2, 16'd0, 1'b0);
      tick(); chk("t1_beat3", 5'b00001, 3'd0, 8'd3, 16'd0, 1'b0);
      tick(); chk("t1_release", 5'b00000, 3'd0, 8'd4, 16'd1, 1'b0);
      tick(); chk("t1_regrant", 5'b00001, 3'd0, 8'd0, 16'd1, 1'b0);
      do_reset("reset_mid_grant");
      // all request, last on every beat: strict rotation with idle gaps
      bus.req = 5'b11111;
      bus.last = 5'b11111;
      bus.res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(); chk("t2_grant", 5'(1 << k), 3'(k), 8'd0, 16'(k), 1'b0);
         tick(); chk("t2_idle", 5'b00000, 3'd0, 8'd1, 16'(k + 1), 1'b0);
      end
      tick(); chk("t2_wrap", 5'b00001, 3'd0, 8'd0, 16'd5, 1'b0);
      tick(); chk("t2_wrap_rel", 5'b00000, 3'd0, 8'd1, 16'd6, 1'b0);
      // serve child 2 to leave ptr=3, then requesters 0 and 2
      bus.req = 5'b00100;
      tick(); chk("t3_c2", 5'b00100, 3'd2, 8'd0, 16'd6, 1'b0);
      tick(); chk("t3_c2_rel", 5'b00000, 3'd0, 8'd1, 16'd7, 1'b0);
      bus.req = 5'b00101;
      tick(); chk("t3_wrap_c0", 5'b00001, 3'd0, 8'd0, 16'd7, 1'b0);
      tick(); chk("t3_c0_rel", 5'b00000, 3'd0, 8'd1, 16'd8, 1'b0);
      tick(); chk("t3_then_c2", 5'b00100, 3'd2, 8'd0, 16'd8, 1'b0);
      tick(); chk("t3_c2_rel2", 5'b00000, 3'd0, 8'd1, 16'd9, 1'b0);
      // child 1 with toggling res_ready; last without ready is no beat
      bus.req = 5'b00010;
      bus.last = 5'b00000;
      bus.res_ready = 1'b0;
      tick(); chk("t4_grant", 5'b00010, 3'd1, 8'd0, 16'd9, 1'b0);
      bus.res_ready = 1'b1;
      tick(); chk("t4_rdy1", 5'b00010, 3'd1, 8'd1, 16'd9, 1'b0);
      bus.res_ready = 1'b0;
      tick(); chk("t4_rdy0", 5'b00010, 3'd1, 8'd1, 16'd9, 1'b0);
      bus.res_ready = 1'b1;
      tick(); chk("t4_rdy1b", 5'b00010, 3'd1, 8'd2, 16'd9, 1'b0);
      bus.res_ready = 1'b0;
      bus.last = 5'b00010;
      tick(); chk("t4_last_nordy", 5'b00010, 3'd1, 8'd2, 16'd9, 1'b0);
      bus.res_ready = 1'b1;
      tick(); chk("t4_last_rel", 5'b00000, 3'd0, 8'd3, 16'd10, 1'b0);
      bus.last = 5'b00000;
      // child 2 aborts after two beats
      bus.req = 5'b00100;
      tick(); chk("t5_grant", 5'b00100, 3'd2, 8'd0, 16'd10, 1'b0);
      tick(); chk("t5_beat1", 5'b00100, 3'd2, 8'd1, 16'd10, 1'b0);
      tick(); chk("t5_beat2", 5'b00100, 3'd2, 8'd2, 16'd10, 1'b0);
      bus.req = 5'b00000;
      tick(); chk("t5_abort", 5'b00000, 3'd0, 8'd2, 16'd10, 1'b1);
      tick(); chk("t5_abort_end", 5'b00000, 3'd0, 8'd2, 16'd10, 1'b0);
      bus.req = 5'b11111;
      bus.res_ready = 1'b0;
      tick(); chk("t5_ptr3", 5'b01000, 3'd3, 8'd0, 16'd10, 1'b0);
      // async reset mid-grant with beat_cnt=3
      bus.res_ready = 1'b1;
      tick(); chk("t6_beat1", 5'b01000, 3'd3, 8'd1, 16'd10, 1'b0);
      tick(); chk("t6_beat2", 5'b01000, 3'd3, 8'd2, 16'd10, 1'b0);
      tick(); chk("t6_beat3", 5'b01000, 3'd3, 8'd3, 16'd10, 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_async_rst", 5'b00000, 3'd0, 8'd0, 16'd0, 1'b0);
      tick();
      rst = 1'b0;
      bus.req = 5'b10000;
      bus.res_ready = 1'b0;
      tick(); chk("t6_c4", 5'b10000, 3'd4, 8'd0, 16'd0, 1'b0);
      bus.req = 5'b00000;
      tick(); chk("t6_c4_abort", 5'b00000, 3'd0, 8'd0, 16'd0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/child_rr_scheduler.md
Name: child_rr_scheduler

Overview:
Round-robin scheduler that shares one downstream resource slot among the NUM_REQ child instances of a hierarchy level (five per level in the generated module tree). Each child raises a request. The scheduler grants exactly one child at a time and meters its burst of beats against the resource-side ready. It then rotates priority. It sits beside the child instances in the parent level and drives only grant and status outputs; it has no datapath.

Parameters:
NUM_REQ, 5, number of requesting children (2..16)
MAX_BURST, 4, maximum beats per grant before forced release (1..255)
IDX_W, 3, width of grant index; must satisfy 2**IDX_W >= NUM_REQ
CNT_W, 16, width of completed-grant counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-child request, level; held until granted or abandoned
last  in  NUM_REQ  per-child end-of-transaction marker, qualified by a beat
res_ready  in  1  resource accepts a beat this cycle
gnt  out  NUM_REQ  one-hot grant, registered
gnt_valid  out  1  OR of gnt, registered
gnt_idx  out  IDX_W  index of granted child; 0 when gnt_valid=0
beat_cnt  out  8  beats consumed in current grant
grant_cnt  out  CNT_W  completed grants, saturating
abort_pulse  out  1  one-cycle pulse when a grant ends by request drop

Behaviour:
- Reset (async assert, sync-released use): state=ARB, gnt=0, gnt_valid=0, gnt_idx=0, beat_cnt=0, grant_cnt=0, abort_pulse=0, priority pointer ptr=0.
- States: ARB, GRANT.
- ARB: if any req bit is set, winner = first set bit searching ptr, ptr+1, ... wrapping modulo NUM_REQ. Next cycle: gnt=onehot(winner), gnt_idx=winner, beat_cnt=0, state=GRANT. If no req bit is set, remain in ARB with outputs 0.
- Grant latency: req asserted in cycle N while in ARB gives gnt visible in cycle N+1.
- GRANT: beat = gnt_valid & res_ready & req[gnt_idx]. Each beat increments beat_cnt.
- Normal release: a beat with last[gnt_idx]=1, or a beat with beat_cnt==MAX_BURST-1. Next cycle: gnt=0, state=ARB, ptr=(gnt_idx+1) mod NUM_REQ, grant_cnt+1 (saturating at all-ones).
- Abort release: req[gnt_idx]=0 while in GRANT. Same transitions as normal release, but grant_cnt is not incremented and abort_pulse=1 for exactly one cycle. Abort takes precedence over a simultaneous beat; no beat is counted.
- Release always produces one idle cycle with gnt=0 before the next grant. Maximum throughput is one grant per MAX_BURST+1 cycles.
- last or res_ready on non-granted children is ignored. last without res_ready is not a beat.
- beat_cnt holds its final value during the idle ARB cycle and clears on the next grant.
- ptr wraps from NUM_REQ-1 to 0. Index values at or above NUM_REQ are never produced.
- Starvation bound: a continuously requesting child is granted within NUM_REQ-1 foreign grants.
- Reset asserted mid-grant: all outputs clear immediately (asynchronous). The interrupted grant is not counted. The first arbitration after reset starts at ptr=0.
- gnt is always one-hot or zero. gnt_valid == |gnt, and gnt_idx is consistent with gnt in every cycle.

Test Plan:
1. Reset, then req=5'b00001 held, res_ready=1, last never -> gnt=00001 one cycle after req; beat_cnt goes 1,2,3,4; release after the 4th beat; one idle cycle; re-grant to child 0; grant_cnt=1 after the first release.
2. req=5'b11111 held, res_ready=1, last on every beat -> grant order 0,1,2,3,4,0, each grant 1 cycle followed by 1 idle cycle; grant_cnt=5 after the fifth release.
3. ptr=3 state (after serving child 2), req=5'b00101 -> next grant goes to child 0 (wrap past 3 and 4), then child 2.
4. Child 1 granted, res_ready toggles 1,0,1,0 -> beat_cnt increments only on ready cycles; last asserted with res_ready=0 does not release.
5. Child 2 granted with beat_cnt=2, then req[2] drops -> abort_pulse=1 for one cycle, grant_cnt unchanged, ptr=3.
6. Assert rst during GRANT with beat_cnt=3 -> gnt, gnt_valid, beat_cnt and grant_cnt read 0 in the same cycle; after release with req=5'b10000, child 4 is granted one cycle later.
